// File: rtl/tap_pkg.sv
// Shared JTAG TAP definitions: the 1149.1 state encoding, default opcodes and
// a printable state name for debug output.
package tap_pkg;

  typedef enum logic [3:0] {
    TLR_S     = 4'hF,
    RTI_S     = 4'hC,
    SEL_DR_S  = 4'h7,
    CAP_DR_S  = 4'h6,
    SH_DR_S   = 4'h2,
    EX1_DR_S  = 4'h1,
    PAU_DR_S  = 4'h3,
    EX2_DR_S  = 4'h0,
    UPD_DR_S  = 4'h5,
    SEL_IR_S  = 4'h4,
    CAP_IR_S  = 4'hE,
    SH_IR_S   = 4'hA,
    EX1_IR_S  = 4'h9,
    PAU_IR_S  = 4'hB,
    EX2_IR_S  = 4'h8,
    UPD_IR_S  = 4'hD
  } tap_state_e;

  localparam logic [3:0] BYPASS_OP_DEF = 4'b1111;
  localparam logic [3:0] IDCODE_OP_DEF = 4'b0010;

  // Six ASCII characters packed into a vector so it prints with %s.
  function automatic logic [47:0] state_name(input logic [3:0] s);
    case (s)
      4'hF:    state_name = "TLR   ";
      4'hC:    state_name = "RTI   ";
      4'h7:    state_name = "SELDR ";
      4'h6:    state_name = "CAPDR ";
      4'h2:    state_name = "SHDR  ";
      4'h1:    state_name = "EX1DR ";
      4'h3:    state_name = "PAUDR ";
      4'h0:    state_name = "EX2DR ";
      4'h5:    state_name = "UPDDR ";
      4'h4:    state_name = "SELIR ";
      4'hE:    state_name = "CAPIR ";
      4'hA:    state_name = "SHIR  ";
      4'h9:    state_name = "EX1IR ";
      4'hB:    state_name = "PAUIR ";
      4'h8:    state_name = "EX2IR ";
      default: state_name = "UPDIR ";
    endcase
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// Pin-side and chain-side signals of the TAP controller, bundled for the top.
interface tap_controller_if #(
  parameter int IW = 4
);
  logic          TMS;
  logic [IW-1:0] LATCH_IR;
  logic          I_TDO;
  logic          BYP_TDO;
  logic          ID_TDO;
  logic          TLR;
  logic          RTI;
  logic          CAPTURE_IR;
  logic          SHIFT_IR;
  logic          UPDATE_IR;
  logic          CAPTURE_DR;
  logic          SHIFT_DR;
  logic          UPDATE_DR;
  logic          SEL_BYPASS;
  logic          SEL_IDCODE;
  logic          TDO;
  logic          TDO_EN;
  logic [3:0]    STATE;

  modport master (
    output TMS, LATCH_IR, I_TDO, BYP_TDO, ID_TDO,
    input  TLR, RTI, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR,
           UPDATE_DR, SEL_BYPASS, SEL_IDCODE, TDO, TDO_EN, STATE
  );

  modport slave (
    input  TMS, LATCH_IR, I_TDO, BYP_TDO, ID_TDO,
    output TLR, RTI, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR,
           UPDATE_DR, SEL_BYPASS, SEL_IDCODE, TDO, TDO_EN, STATE
  );
endinterface

// File: rtl/tap_state_decode.sv
// Moore decode of the registered TAP state into the IR/DR strobes and TDO_EN.
module tap_state_decode
  import tap_pkg::*;
(
  input  tap_state_e state,
  output logic       tlr,
  output logic       rti,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       tdo_en
);

  always_comb begin
    tlr        = 1'b0;
    rti        = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    case (state)
      TLR_S:    tlr        = 1'b1;
      RTI_S:    rti        = 1'b1;
      CAP_IR_S: capture_ir = 1'b1;
      SH_IR_S:  shift_ir   = 1'b1;
      UPD_IR_S: update_ir  = 1'b1;
      CAP_DR_S: capture_dr = 1'b1;
      SH_DR_S:  shift_dr   = 1'b1;
      UPD_DR_S: update_dr  = 1'b1;
      default:  ;
    endcase
    tdo_en = shift_ir | shift_dr;
  end

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine: TMS-driven state register, strobe decode,
// instruction decode and the TDO output mux.
module tap_controller
  import tap_pkg::*;
#(
  parameter int                       IR_DATA_WIDTH = 4,
  parameter logic [IR_DATA_WIDTH-1:0] BYPASS_OP     = IR_DATA_WIDTH'(BYPASS_OP_DEF),
  parameter logic [IR_DATA_WIDTH-1:0] IDCODE_OP     = IR_DATA_WIDTH'(IDCODE_OP_DEF)
) (
  input  logic             TCK,
  input  logic             TRST,
  tap_controller_if.slave  bus
);

  tap_state_e state_p0;
  tap_state_e state_nxt;
  logic       is_byp;
  logic       is_id;

  // Stage p0: TAP state register, reset forces Test-Logic-Reset over TMS
  always_ff @(posedge TCK) begin
    if (TRST) state_p0 <= TLR_S;
    else      state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      TLR_S:    state_nxt = bus.TMS ? TLR_S    : RTI_S;
      RTI_S:    state_nxt = bus.TMS ? SEL_DR_S : RTI_S;
      SEL_DR_S: state_nxt = bus.TMS ? SEL_IR_S : CAP_DR_S;
      CAP_DR_S: state_nxt = bus.TMS ? EX1_DR_S : SH_DR_S;
      SH_DR_S:  state_nxt = bus.TMS ? EX1_DR_S : SH_DR_S;
      EX1_DR_S: state_nxt = bus.TMS ? UPD_DR_S : PAU_DR_S;
      PAU_DR_S: state_nxt = bus.TMS ? EX2_DR_S : PAU_DR_S;
      EX2_DR_S: state_nxt = bus.TMS ? UPD_DR_S : SH_DR_S;
      UPD_DR_S: state_nxt = bus.TMS ? SEL_DR_S : RTI_S;
      SEL_IR_S: state_nxt = bus.TMS ? TLR_S    : CAP_IR_S;
      CAP_IR_S: state_nxt = bus.TMS ? EX1_IR_S : SH_IR_S;
      SH_IR_S:  state_nxt = bus.TMS ? EX1_IR_S : SH_IR_S;
      EX1_IR_S: state_nxt = bus.TMS ? UPD_IR_S : PAU_IR_S;
      PAU_IR_S: state_nxt = bus.TMS ? EX2_IR_S : PAU_IR_S;
      EX2_IR_S: state_nxt = bus.TMS ? UPD_IR_S : SH_IR_S;
      UPD_IR_S: state_nxt = bus.TMS ? SEL_DR_S : RTI_S;
      default:  state_nxt = TLR_S;
    endcase
  end

  tap_state_decode u_decode (
    .state      (state_p0),
    .tlr        (bus.TLR),
    .rti        (bus.RTI),
    .capture_ir (bus.CAPTURE_IR),
    .shift_ir   (bus.SHIFT_IR),
    .update_ir  (bus.UPDATE_IR),
    .capture_dr (bus.CAPTURE_DR),
    .shift_dr   (bus.SHIFT_DR),
    .update_dr  (bus.UPDATE_DR),
    .tdo_en     (bus.TDO_EN)
  );

  // Any opcode other than IDCODE is served by the bypass register.
  assign is_byp         = (bus.LATCH_IR == BYPASS_OP);
  assign is_id          = (bus.LATCH_IR == IDCODE_OP);
  assign bus.SEL_IDCODE = is_id & ~is_byp;
  assign bus.SEL_BYPASS = is_byp | ~is_id;
  assign bus.STATE      = state_p0;

  always_comb begin
    bus.TDO = 1'b0;
    if (state_p0 == SH_IR_S)      bus.TDO = bus.I_TDO;
    else if (state_p0 == SH_DR_S) bus.TDO = bus.SEL_IDCODE ? bus.ID_TDO : bus.BYP_TDO;
  end

endmodule
